phase_sequencer: RTL
====================

# phase_sequencer

Phase sequencer for the VeriRisc CPU. It generates the 3-bit `phase` that the instruction controller decodes, and manages the run, halt and single-step modes. It sits directly upstream of the controller and consumes that controller's `halt` output. It also reports instruction retirement to the rest of the CPU and to the test bench.

## Interface
Parameters:
- `AUTO_START`, default 1: 1 means the block leaves reset in RUN; 0 means it leaves reset in IDLE and waits for `go`.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_`  input  1  reset, asynchronous, active-low.
- `halt`  input  1  halt request from the controller; valid only in phase 4.
- `go`  input  1  start/resume request; sampled every edge, one cycle wide or longer.
- `step_mode`  input  1  1 means execute exactly one instruction per accepted `go`.
- `phase`  output  3  current instruction phase, 0..7, to the controller.
- `running`  output  1  high while state is RUN.
- `halted`  output  1  high while state is HALTED.
- `instr_done`  output  1  one-cycle pulse in the cycle after an instruction retires.
- `instr_count`  output  CNT_W  count of retired instructions, saturating.

## Operation
- Three states: IDLE, RUN, HALTED. The state register is 2 bits.
- **RUN**
  - `phase` increments by 1 each edge and wraps from 7 to 0.
  - An instruction retires on the 7→0 edge.
- **Halt handling**
  - If `halt`=1 at an edge where `phase`=4: the next state is HALTED and `phase` is forced to 0. Phases 5–7 are skipped.
  - That instruction counts as retired. The controller's `inc_pc` on the same edge still takes effect downstream.
  - `halt`=1 in any other phase or any other state is ignored.
- **Step mode**
  - If `step_mode`=1 on a retiring 7→0 edge, the next state is IDLE with `phase`=0.
  - If `halt` applies at phase 4 while `step_mode`=1, halt wins and the next state is HALTED.
- **IDLE and HALTED**
  - `phase` is held at 0.
  - `go`=1 gives next state RUN, so `phase` becomes 1 on the following edge.
  - Resuming from HALTED continues with the next instruction; the program counter was already incremented.
- `go` in RUN is ignored.
- `step_mode` may change at any time. It is only examined on retiring edges.
- **Counter**
  - `instr_count` increments by 1 on every retiring edge: the 7→0 wrap or the halt abort.
  - It saturates at 2^CNT_W−1 and never wraps.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset values:
  - `phase`=0.
  - `running`=AUTO_START.
  - `halted`=0.
  - `instr_done`=0.
  - `instr_count`=0.
  - State is RUN if AUTO_START=1, otherwise IDLE.
- A reset asserted mid-instruction clears everything immediately and asynchronously. No retirement is counted.
- A full instruction takes 8 cycles from phase 0 to the next phase 0. A halted instruction takes 5 cycles.
- Latency from `go` to `phase`=1 is 2 edges. The first edge moves the state to RUN while phase stays 0; the second advances phase.
- `instr_done` is high for exactly the one cycle following each retiring edge, aligned with `phase`=0.
- `running` and `halted` update on the same edge as the state change.

## Configuration
- Macro `PHASE_SEQ_CNT_EN`.
- When defined: the retirement counter is built as described above.
- When undefined: there is no counter logic and `instr_count` is tied to 0. `instr_done` still works.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum (IDLE, RUN, HALTED);
  - phase constants `PH_FETCH`=0 and `PH_HALT_CHK`=4;
  - the `PHASE_W`=3 constant, which is also used by the controller.
- One sub-module, `sat_counter`: a parameterised saturating up-counter with an increment enable. It is instantiated only under `PHASE_SEQ_CNT_EN`.

## Test plan
- **Reset with AUTO_START=1, `halt`=0, `step_mode`=0**
  - Stimulus: release reset and run 16 edges.
  - Required: `phase` steps 0,1,…,7,0,… and `instr_done` pulses twice.
  - Required: `instr_count`=2 and `running`=1 throughout.
- **Halt**
  - Stimulus: drive `halt`=1 while `phase`=4.
  - Required: next `phase`=0, `halted`=1 and `running`=0; `instr_done` pulses once and `instr_count` increments.
  - Required: `phase` stays 0 for 10 further edges. Then `go`=1 gives state RUN, and `phase`=1 one edge later.
- **Step mode**
  - Stimulus: `step_mode`=1, AUTO_START=0, one `go` pulse.
  - Required: exactly 8 phases 0–7 run, the block returns to IDLE with `phase`=0, and `instr_count`=1.
  - Required: a second `go` runs exactly one more instruction.
- **Halt outside phase 4 ignored**
  - Stimulus: `halt`=1 in phases 0–3 and 5–7.
  - Required: the sequence is unaffected and no HALTED state is entered.
- **Reset mid-instruction**
  - Stimulus: assert `rst_` low while `phase`=6.
  - Required: all outputs go to their reset values before the next edge, and `instr_count`=0.
- **Saturation**
  - Stimulus: CNT_W=2, run 6 instructions.
  - Required: `instr_count` sequence is 1,2,3,3,3,3, and `instr_done` still pulses 6 times.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared VeriRisc CPU types and phase constants
//
// Contents:
//   PHASE_W      width of the instruction phase bus (also used by the controller)
//   PH_FETCH     first phase of an instruction (0)
//   PH_HALT_CHK  phase in which the controller's halt output is valid (4)
//   PH_LAST      final phase before the wrap back to PH_FETCH (7)
//   seq_state_t  phase sequencer mode: IDLE, RUN, HALTED
package cpu_pkg;

  localparam int PHASE_W = 3;

  localparam logic [PHASE_W-1:0] PH_FETCH    = 3'd0;
  localparam logic [PHASE_W-1:0] PH_HALT_CHK = 3'd4;
  localparam logic [PHASE_W-1:0] PH_LAST     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with increment enable
//
// Parameters:
//   W      counter width
// Ports:
//   clk    input   rising-edge clock
//   rst_   input   asynchronous active-low reset, clears the count
//   en     input   increment request for this edge
//   count  output  current count, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - VeriRisc instruction phase sequencer with run/halt/step control
//
// Optional feature macro: PHASE_SEQ_CNT_EN builds the retired-instruction
// counter; without it instr_count is tied to 0.
//
// Parameters:
//   AUTO_START   1: leave reset in RUN, 0: leave reset in IDLE and wait for go
//   CNT_W        width of the retired-instruction counter
// Ports:
//   clk          input   rising-edge clock
//   rst_         input   asynchronous active-low reset
//   halt         input   controller halt request, honoured only in phase 4 of RUN
//   go           input   start/resume request from IDLE or HALTED
//   step_mode    input   stop in IDLE after each retired instruction
//   phase        output  current instruction phase 0..7
//   running      output  state is RUN
//   halted       output  state is HALTED
//   instr_done   output  one-cycle pulse after each retiring edge
//   instr_count  output  saturating count of retired instructions
module phase_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned AUTO_START = 1,
  parameter int          CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               halt,
  input  logic               go,
  input  logic               step_mode,
  output logic [PHASE_W-1:0] phase,
  output logic               running,
  output logic               halted,
  output logic               instr_done,
  output logic [CNT_W-1:0]   instr_count
);

  localparam seq_state_t RESET_STATE = (AUTO_START != 0) ? ST_RUN : ST_IDLE;

  seq_state_t         state;
  seq_state_t         state_nxt;
  logic [PHASE_W-1:0] phase_nxt;
  logic               retire;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= RESET_STATE;
      phase      <= PH_FETCH;
      running    <= (AUTO_START != 0);
      halted     <= 1'b0;
      instr_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      // Flags follow the next state so they change on the same edge as state.
      running    <= (state_nxt == ST_RUN);
      halted     <= (state_nxt == ST_HALTED);
      instr_done <= retire;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = PH_FETCH;
    retire    = 1'b0;
    case (state)
      ST_RUN: begin
        if ((phase == PH_HALT_CHK) && halt) begin
          // Abort phases 5..7; the instruction still counts as retired
          // because the controller's inc_pc on this edge takes effect.
          // Halt outranks step_mode.
          state_nxt = ST_HALTED;
          retire    = 1'b1;
        end else if (phase == PH_LAST) begin
          retire = 1'b1;
          if (step_mode) begin
            state_nxt = ST_IDLE;
          end
        end else begin
          phase_nxt = phase + PHASE_W'(1);
        end
      end
      ST_IDLE, ST_HALTED: begin
        // Phase stays at 0 on the go edge; it advances on the following one.
        if (go) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef PHASE_SEQ_CNT_EN
  sat_counter #(
    .W (CNT_W)
  ) u_retire_cnt (
    .clk   (clk),
    .rst_  (rst_),
    .en    (retire),
    .count (instr_count)
  );
`else
  assign instr_count = '0;
`endif

endmodule
